uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx_cfg.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and the future transmitter.
//   - uart_state_e      : receiver FSM state encoding
//   - UART_*_MIN/_MAX   : legal ranges of the configuration parameters
//   - uart_params_legal : constant function used to check a configuration
//                         when the design is elaborated
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int UART_DATA_BITS_MIN  = 5;
    localparam int UART_DATA_BITS_MAX  = 9;
    localparam int UART_OVERSAMPLE_MIN = 8;
    localparam int UART_OVERSAMPLE_MAX = 32;
    localparam int UART_STOP_BITS_MIN  = 1;
    localparam int UART_STOP_BITS_MAX  = 2;

    // Returns 1 when every configuration parameter is inside its legal range.
    function automatic logic uart_params_legal(input int data_bits,
                                               input int oversample,
                                               input int stop_bits,
                                               input int parity_odd);
        return (data_bits  >= UART_DATA_BITS_MIN)  && (data_bits  <= UART_DATA_BITS_MAX)  &&
               (oversample >= UART_OVERSAMPLE_MIN) && (oversample <= UART_OVERSAMPLE_MAX) &&
               ((oversample % 2) == 0) &&
               (stop_bits  >= UART_STOP_BITS_MIN)  && (stop_bits  <= UART_STOP_BITS_MAX)  &&
               ((parity_odd == 0) || (parity_odd == 1));
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both flops reset to 1 so that the line looks idle straight out of reset.
//   clk : system clock
//   rst : synchronous, active-high reset
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
// Oversampling UART receiver with configurable payload width, oversampling
// ratio, stop-bit count and optional parity checking.
//
// Build option: define UART_RX_PARITY_EN to include the PARITY state and the
// parity check; without it STOP follows DATA and parity_err is constant 0.
//
// Parameters
//   DATA_BITS  : payload bits per frame (5..9)
//   OVERSAMPLE : baud_tick pulses per bit period (even, 8..32)
//   STOP_BITS  : stop bits checked per frame (1 or 2)
//   PARITY_ODD : 0 = even parity, 1 = odd parity
// Ports
//   clk          : system clock
//   rst          : synchronous, active-high reset
//   baud_tick    : one-clk pulse at OVERSAMPLE x baud rate
//   rx           : asynchronous serial line, idle high
//   rx_done_tick : one-clk pulse when a frame completes
//   data_out     : last received payload (first bit on the line in bit 0)
//   frame_err    : a stop bit was sampled low in the last frame
//   parity_err   : parity mismatch in the last frame
//   busy         : high whenever the receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic                 rx_done_tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 4;

    localparam logic [TICK_W-1:0] TICK_MID       = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE       = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST_DATA  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE        = BIT_W'(1);

    // An illegal configuration leaves this named scope in the elaborated
    // hierarchy, which makes it easy to spot in a netlist or hierarchy dump.
    if (!uart_params_legal(DATA_BITS, OVERSAMPLE, STOP_BITS, PARITY_ODD)) begin : g_illegal_params
    end

    logic rx_s;

    uart_state_e             state_q,     state_d;
    logic [TICK_W-1:0]       tick_q,      tick_d;
    logic [BIT_W-1:0]        bit_q,       bit_d;
    logic [DATA_BITS-1:0]    shift_q,     shift_d;
    logic                    ferr_acc_q,  ferr_acc_d;
    logic                    done_q,      done_d;
    logic [DATA_BITS-1:0]    data_q,      data_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q;
`ifdef UART_RX_PARITY_EN
    logic                    par_acc_q,    par_acc_d;
    logic                    parity_err_q, parity_err_d;

    // 1 when the payload plus received parity bit disagree with the chosen sense.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                             input logic                 p);
        logic odd_sense;
        odd_sense = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
        return (^{d, p}) != odd_sense;
    endfunction
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state and datapath decode for the receive FSM.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        ferr_acc_d  = ferr_acc_q;
        done_d      = 1'b0;
        data_d      = data_q;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_acc_d    = par_acc_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    tick_d  = '0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (rx_s) begin
                            // Line went back high before mid-bit: a glitch.
                            state_d = ST_IDLE;
                        end else begin
                            tick_d     = '0;
                            bit_d      = '0;
                            ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_acc_d  = 1'b0;
`endif
                            state_d    = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        // Shift in at the MSB so the first bit lands in bit 0.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST_DATA) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        par_acc_d = parity_mismatch(shift_q, rx_s);
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST_STOP) begin
                            // Last stop sample: publish the whole frame at once.
                            bit_d       = '0;
                            done_d      = 1'b1;
                            data_d      = shift_q;
                            frame_err_d = ferr_acc_q | ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = par_acc_q;
`endif
                            state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            ferr_acc_d = ferr_acc_q | ~rx_s;
                            bit_d      = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not start another frame.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ferr_acc_q  <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ferr_acc_q  <= ferr_acc_d;
            done_q      <= done_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= par_acc_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_done_tick = done_q;
    assign data_out     = data_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = parity_err_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
